// File: rtl/nic_tx_arbiter_if.sv
// Requester and NIC register bus bundle for the TX arbiter.
// master = arbiter side, slave = requesters plus NIC side.
interface nic_tx_arbiter_if;
  logic [3:0]   req;
  logic [255:0] req_data;
  logic [3:0]   ack;
  logic [1:0]   nic_addr;
  logic [63:0]  nic_d_in;
  logic [63:0]  nic_d_out;
  logic         nic_en;
  logic         nic_en_wr;

  modport master (
    input  req,
    input  req_data,
    input  nic_d_out,
    output ack,
    output nic_addr,
    output nic_d_in,
    output nic_en,
    output nic_en_wr
  );

  modport slave (
    output req,
    output req_data,
    output nic_d_out,
    input  ack,
    input  nic_addr,
    input  nic_d_in,
    input  nic_en,
    input  nic_en_wr
  );
endinterface

// File: rtl/nic_tx_arbiter.sv
// Round-robin arbiter feeding packets from 4 requesters into a NIC
// output buffer: poll status, write when free, then ack the winner.
module nic_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  nic_tx_arbiter_if.master bus,
  output logic             busy,
  output logic [CNT_W-1:0] tx_count
);

  typedef enum logic [1:0] {
    IDLE,
    POLL,
    CHECK,
    WRITE
  } state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [1:0]       winner;
  logic [63:0]      pkt;
  logic [N_REQ-1:0] ack_q;
  logic [N_REQ-1:0] elig;
  logic             gnt_vld;
  logic [1:0]       gnt_idx;
  logic [1:0]       idx;
  logic             unused_status;

  assign unused_status = ^bus.nic_d_out[63:1];

  // A requester being acked this cycle sits out one arbitration.
  assign elig = bus.req & ~ack_q;

  // Scan from the highest offset down so the nearest one to ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr;
    idx     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    bus.nic_en    = 1'b0;
    bus.nic_en_wr = 1'b0;
    bus.nic_addr  = 2'b00;
    unique case (state)
      POLL: begin
        bus.nic_en   = 1'b1;
        bus.nic_addr = 2'b11;
      end
      WRITE: begin
        bus.nic_en    = 1'b1;
        bus.nic_en_wr = 1'b1;
        bus.nic_addr  = 2'b10;
      end
      default: ;
    endcase
  end

  assign busy         = (state != IDLE);
  assign bus.ack      = ack_q;
  assign bus.nic_d_in = pkt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      winner   <= '0;
      pkt      <= '0;
      ack_q    <= '0;
      tx_count <= '0;
    end else begin
      ack_q <= '0;
      unique case (state)
        IDLE: begin
          if (gnt_vld) begin
            winner <= gnt_idx;
            pkt    <= bus.req_data[{gnt_idx, 6'd0} +: 64];
            state  <= POLL;
          end
        end
        POLL: state <= CHECK;
        // Status bit 0 set means the output buffer is still full.
        CHECK: state <= bus.nic_d_out[0] ? POLL : WRITE;
        WRITE: begin
          ack_q[winner] <= 1'b1;
          ptr           <= winner + 2'd1;
          tx_count      <= tx_count + 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nic_tx_arbiter.sv
// Self-checking bench for nic_tx_arbiter against a transaction-level
// round-robin model and a small NIC status/write responder.
module tb_nic_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic [15:0] tx_count;
  logic        wreset;
  logic        wbusy;
  logic [2:0]  wcnt;

  int n_run  = 0;
  int n_fail = 0;

  nic_tx_arbiter_if bus ();
  nic_tx_arbiter_if wbus ();

  nic_tx_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .tx_count (tx_count)
  );

  nic_tx_arbiter #(.CNT_W(3)) dut_w (
    .clk      (clk),
    .reset    (wreset),
    .bus      (wbus),
    .busy     (wbusy),
    .tx_count (wcnt)
  );

  always #5 clk = ~clk;

  // NIC responder: status reads busy for busy_n polls after poll_base
  int          n_polls  = 0;
  int          n_writes = 0;
  int          poll_base = 0;
  int          busy_n   = 0;
  logic [63:0] last_wr  = '0;
  logic [1:0]  wr_addr  = '0;

  always @(posedge clk) begin
    if (bus.nic_en && !bus.nic_en_wr && bus.nic_addr == 2'b11) begin
      bus.nic_d_out <= {63'd0, (n_polls - poll_base) < busy_n};
      n_polls <= n_polls + 1;
    end
    if (bus.nic_en && bus.nic_en_wr) begin
      n_writes <= n_writes + 1;
      last_wr  <= bus.nic_d_in;
      wr_addr  <= bus.nic_addr;
    end
  end

  // Reference model state
  int          m_ptr = 0;
  logic [3:0]  m_ack = '0;
  logic [15:0] m_cnt = '0;

  function automatic int pick(input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (m_ptr + k) % 4;
      if (r[j] && !m_ack[j]) return j;
    end
    return -1;
  endfunction

  task automatic idle(input int n);
    bus.req = '0;
    repeat (n) @(negedge clk);
    m_ack = '0;
  endtask

  task automatic do_xfer(input logic [3:0] r, input int nb, input bit drop);
    logic [63:0] pk[4];
    logic [63:0] exp_d;
    logic [3:0]  eack;
    int w, cyc, p0, w0;
    for (int k = 0; k < 4; k++) pk[k] = {$urandom, $urandom};
    bus.req_data = {pk[3], pk[2], pk[1], pk[0]};
    bus.req = r;
    w = pick(r);
    if (w < 0) begin
      n_run++; n_fail++;
      $display("FAIL stim_no_eligible req=%b ack=%b", r, m_ack);
      return;
    end
    exp_d = pk[w];
    eack = 4'b0001 << w;
    poll_base = n_polls;
    busy_n = nb;
    p0 = n_polls;
    w0 = n_writes;
    @(negedge clk);
    cyc = 1;
    n_run++;
    if (busy !== 1'b1 || bus.nic_en !== 1'b1 || bus.nic_en_wr !== 1'b0 ||
        bus.nic_addr !== 2'b11) begin
      n_fail++;
      $display("FAIL grant_poll busy=%b en=%b wr=%b addr=%b want 1/1/0/11",
               busy, bus.nic_en, bus.nic_en_wr, bus.nic_addr);
    end
    bus.req_data = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
    if (drop) bus.req = '0;
    while (bus.ack === 4'b0000 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    n_run++;
    if (bus.ack !== eack) begin
      n_fail++;
      $display("FAIL ack got=%b want=%b", bus.ack, eack);
    end
    n_run++;
    if (cyc != 4 + 2 * nb) begin
      n_fail++;
      $display("FAIL latency got=%0d want=%0d", cyc, 4 + 2 * nb);
    end
    n_run++;
    if (n_polls - p0 != nb + 1 || n_writes - w0 != 1 || wr_addr !== 2'b10) begin
      n_fail++;
      $display("FAIL nic_access polls=%0d want=%0d writes=%0d want=1 addr=%b",
               n_polls - p0, nb + 1, n_writes - w0, wr_addr);
    end
    n_run++;
    if (last_wr !== exp_d || bus.nic_d_in !== exp_d) begin
      n_fail++;
      $display("FAIL wr_data got=%h hold=%h want=%h", last_wr, bus.nic_d_in, exp_d);
    end
    m_cnt = m_cnt + 16'd1;
    n_run++;
    if (tx_count !== m_cnt || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_count got=%h want=%h busy=%b", tx_count, m_cnt, busy);
    end
    m_ptr = (w + 1) % 4;
    m_ack = eack;
  endtask

  task automatic chk_reset_vals(input string tag);
    n_run++;
    if (bus.ack !== 4'b0 || busy !== 1'b0 || tx_count !== 16'd0 ||
        bus.nic_en !== 1'b0 || bus.nic_en_wr !== 1'b0 ||
        bus.nic_addr !== 2'b00 || bus.nic_d_in !== 64'd0) begin
      n_fail++;
      $display("FAIL %s ack=%b busy=%b cnt=%h en=%b wr=%b addr=%b d=%h want all 0",
               tag, bus.ack, busy, tx_count, bus.nic_en, bus.nic_en_wr,
               bus.nic_addr, bus.nic_d_in);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.req = '0;
    bus.req_data = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset_state");
    reset = 1'b1;
    m_ptr = 0; m_ack = '0; m_cnt = '0;
    @(negedge clk);
    do_xfer(4'b1100, 0, 1'b0);
    idle(2);
  endtask

  task automatic test_single();
    logic [63:0] d;
    int w0;
    d = 64'hA5A5_0000_0000_0001;
    idle(1);
    m_ptr = 0;
    w0 = n_writes;
    do_xfer(4'b0001, 0, 1'b0);
    n_run++;
    if (last_wr !== bus.nic_d_in || n_writes - w0 != 1) begin
      n_fail++;
      $display("FAIL single_write got=%h", last_wr);
    end
    idle(2);
    bus.req_data = '0;
    bus.req_data[63:0] = d;
    bus.req = 4'b0001;
    poll_base = n_polls; busy_n = 0;
    repeat (4) @(negedge clk);
    n_run++;
    if (bus.ack !== 4'b0001 || last_wr !== d) begin
      n_fail++;
      $display("FAIL single_fixed ack=%b data=%h want 0001 %h", bus.ack, last_wr, d);
    end
    m_cnt = m_cnt + 16'd1;
    m_ptr = 1;
    idle(2);
  endtask

  task automatic test_round_robin();
    idle(1);
    for (int k = 0; k < 5; k++) do_xfer(4'b1111, 0, 1'b0);
    idle(2);
  endtask

  task automatic test_busy_poll();
    do_xfer(4'b0010, 3, 1'b0);
    idle(2);
  endtask

  task automatic test_no_back_to_back();
    do_xfer(4'b0100, 0, 1'b0);
    do_xfer(4'b1100, 0, 1'b0);
    do_xfer(4'b0100, 1, 1'b1);
    idle(2);
  endtask

  task automatic test_mid_reset();
    int w0;
    w0 = n_writes;
    bus.req_data = {4{64'hDEAD_BEEF_0000_1111}};
    bus.req = 4'b0001;
    poll_base = n_polls; busy_n = 0;
    @(negedge clk);
    bus.req = '0;
    @(negedge clk);
    n_run++;
    if (busy !== 1'b1 || bus.nic_en !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_reset_check busy=%b en=%b want 1/0", busy, bus.nic_en);
    end
    #2 reset = 1'b0;
    #1 chk_reset_vals("async_reset");
    repeat (2) @(negedge clk);
    chk_reset_vals("held_reset");
    n_run++;
    if (n_writes != w0) begin
      n_fail++;
      $display("FAIL reset_write got=%0d writes want 0", n_writes - w0);
    end
    reset = 1'b1;
    m_ptr = 0; m_ack = '0; m_cnt = '0;
    @(negedge clk);
    do_xfer(4'b0100, 0, 1'b0);
    idle(2);
  endtask

  task automatic test_random();
    logic [3:0] r;
    for (int k = 0; k < 30; k++) begin
      r = 4'($urandom_range(1, 15));
      if ((r & ~m_ack) == 4'b0) r = ~m_ack;
      do_xfer(r, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(2);
  endtask

  task automatic test_wrap();
    int acks, cyc;
    wreset = 1'b0;
    @(negedge clk);
    wreset = 1'b1;
    acks = 0;
    cyc = 0;
    while (acks < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (wbus.ack !== 4'b0000) begin
        acks++;
        n_run++;
        if (wcnt !== 3'(acks)) begin
          n_fail++;
          $display("FAIL wrap_count ack#%0d got=%0d want=%0d", acks, wcnt, 3'(acks));
        end
      end
    end
    n_run++;
    if (acks != 8) begin
      n_fail++;
      $display("FAIL wrap_timeout acks=%0d want 8", acks);
    end
  endtask

  initial begin
    reset = 1'b0;
    wreset = 1'b0;
    wbus.req = 4'b0001;
    wbus.req_data = {4{64'h0123_4567_89AB_CDEF}};
    wbus.nic_d_out = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_busy_poll();
    test_no_back_to_back();
    test_mid_reset();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/nic_tx_arbiter.md
NIC_TX_ARBITER -- requirements
Module: nic_tx_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of requesters (fixed at 4 in this revision).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the sent-packet counter.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, ports: clk  input  1  system clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 req  input  4  per-requester send request, bit i belongs to requester i.
REQ-006 req_data  input  256  flattened packets, requester i at bits [64i+63:64i].
REQ-007 ack  output  4  one-cycle pulse: requester i's packet has been written to the NIC.
REQ-008 busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 tx_count  output  CNT_W  count of packets written to the NIC, wrapping.
REQ-010 nic_addr  output  2  NIC register address.
REQ-011 nic_d_in  output  64  write data to the NIC.
REQ-012 nic_d_out  input  64  registered read data from the NIC, valid the cycle after a read.
REQ-013 nic_en  output  1  NIC chip-select.
REQ-014 nic_en_wr  output  1  NIC write enable (1 = write, 0 = read).

Function
REQ-015 The FSM SHALL have states IDLE, POLL, CHECK and WRITE, held in a single state register.
REQ-016 nic_en, nic_en_wr and nic_addr SHALL be decoded from the state register only: IDLE/CHECK give 0/0/00, POLL gives 1/0/11 (output status read), WRITE gives 1/1/10 (output buffer write).
REQ-017 In IDLE with any eligible req bit high, the arbiter SHALL grant round-robin starting at pointer ptr (ptr, ptr+1, ... mod 4), latch the winner index and its 64-bit req_data, and go to POLL on the same edge.
REQ-018 A requester whose ack bit is high in the current cycle SHALL be ineligible in that cycle.
REQ-019 POLL SHALL last exactly one cycle and always go to CHECK.
REQ-020 In CHECK the arbiter SHALL sample nic_d_out[0]: 0 (buffer free) goes to WRITE; 1 (buffer full) goes to POLL, retrying indefinitely with no timeout.
REQ-021 WRITE SHALL last exactly one cycle, with nic_d_in equal to the latched packet, and go to IDLE.
REQ-022 On the edge leaving WRITE, the arbiter SHALL set ack[winner] for exactly one cycle, set ptr to (winner+1) mod 4, and increment tx_count.
REQ-023 tx_count SHALL wrap from 2^CNT_W-1 to 0.
REQ-024 nic_d_in SHALL hold the last latched packet in all states.
REQ-025 Packet data SHALL be latched at grant, so req_data changes after grant do not affect the packet written.
REQ-026 A req bit dropped after grant SHALL NOT cancel the transfer; ack still pulses.
REQ-027 Latency from req high in IDLE (NIC buffer free) to ack SHALL be 4 cycles: grant edge, POLL, CHECK, WRITE, then ack.
REQ-028 Each busy poll (nic_d_out[0]=1) SHALL add 2 cycles to that latency.
REQ-029 At most one NIC access SHALL be in flight at any time, and a WRITE SHALL always be preceded by a CHECK that read status 0.

Reset
REQ-030 While reset=0, and immediately on its assertion, all outputs SHALL take their reset values: state IDLE, ptr 0, ack 0000, busy 0, tx_count 0, nic_en 0, nic_en_wr 0, nic_addr 00, nic_d_in 0.
REQ-031 Reset asserted mid-transfer SHALL abandon the latched request without an ack, and no NIC write SHALL occur.
REQ-032 After reset deassertion, the first grant SHALL go to the lowest-index requesting bit.

Verification
REQ-033 Buffer free, req=0001, data0=0xA5A5_0000_0000_0001 -> POLL, CHECK, WRITE with nic_d_in=0xA5A5_0000_0000_0001; ack=0001 on cycle 4; tx_count=1.
REQ-034 req=1111 held and NIC always free -> grants in order 0,1,2,3,0 with ack spaced 4 cycles apart and no requester starved.
REQ-035 NIC status reads 1 for 3 polls, then 0 -> exactly 4 POLL/CHECK pairs, a single WRITE, and ack on cycle 10.
REQ-036 Requester 2 keeps req high through its ack cycle while requester 3 also requests -> requester 3 is granted next; requester 2 is not re-granted back-to-back.
REQ-037 reset pulled low during CHECK -> outputs return to reset values asynchronously, no ack and no WRITE; after release, req=0100 is served normally.
REQ-038 tx_count preset to 0xFFFF via 65535 transfers (or a forced value) -> the next transfer yields tx_count=0x0000.
